// File: rtl/core_seq_ctrl_if.sv
// Memory handshake bundle between the control sequencer and the instruction/data memories.
// The master side is the sequencer; the slave side is the memory subsystem.
interface core_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [31:0]     imem_rdata_i;
  logic            dmem_req_o;
  logic            dmem_ack_i;

  modport master (
    output imem_req_o, imem_addr_o, dmem_req_o,
    input  imem_ack_i, imem_rdata_i, dmem_ack_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, dmem_req_o,
    output imem_ack_i, imem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multicycle control sequencer: register-file clear, then FETCH/DECODE/EXEC/MEM/WB with timeouts.
// Optional performance counters are built only when CORE_SEQ_PERF_CNT_EN is defined.
module core_seq_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              NUM_REGS     = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter int              MEM_TIMEOUT  = 255,
  localparam int             RW           = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  core_seq_ctrl_if.master     bus,
  output logic [31:0]         instr_o,
  input  logic                dec_illegal_i,
  input  logic                dec_mem_i,
  input  logic                dec_we_i,
  input  logic [RW-1:0]       dec_rd_i,
  input  logic [XLEN-1:0]     exec_next_pc_i,
  input  logic [XLEN-1:0]     exec_result_i,
  output logic                rf_we_o,
  output logic [RW-1:0]       rf_waddr_o,
  output logic [XLEN-1:0]     rf_wdata_o,
  output logic [XLEN-1:0]     pc_o,
  output logic                retire_o,
  output logic                halt_o,
  output logic [1:0]          fault_o,
  output logic [63:0]         cycle_cnt_o,
  output logic [63:0]         instret_cnt_o
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [1:0] F_NONE    = 2'd0;
  localparam logic [1:0] F_ILLEGAL = 2'd1;
  localparam logic [1:0] F_IMEM_TO = 2'd2;
  localparam logic [1:0] F_DMEM_TO = 2'd3;

  // Wait counter holds (cycles already spent waiting); the last legal ack cycle is MEM_TIMEOUT-1.
  localparam logic [15:0]   WAIT_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [RW-1:0] CLR_LAST  = RW'(NUM_REGS - 1);

  logic [2:0]      state_q, state_d;
  logic [RW-1:0]   clr_q, clr_d;
  logic [15:0]     wait_q, wait_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [31:0]     instr_q, instr_d;
  logic [1:0]      fault_q, fault_d;

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latches).
    state_d = state_q;
    clr_d   = clr_q;
    wait_d  = wait_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    res_d   = res_q;
    instr_d = instr_q;
    fault_d = fault_q;
    case (state_q)
      S_RESET: begin
        clr_d   = '0;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == CLR_LAST) begin
          wait_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.imem_ack_i) begin
          instr_d = bus.imem_rdata_i;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = F_IMEM_TO;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_DECODE: begin
        if (dec_illegal_i) begin
          fault_d = F_ILLEGAL;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        npc_d = exec_next_pc_i;
        res_d = exec_result_i;
        if (dec_mem_i) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack_i) begin
          res_d   = exec_result_i;
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = F_DMEM_TO;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_WB: begin
        pc_d    = npc_q;
        wait_d  = '0;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst_i) begin
      state_q <= S_RESET;
      clr_q   <= '0;
      wait_q  <= '0;
      pc_q    <= RESET_VECTOR;
      npc_q   <= '0;
      res_q   <= '0;
      instr_q <= '0;
      fault_q <= F_NONE;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      wait_q  <= wait_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      res_q   <= res_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (state_q == S_CLEAR) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = clr_q;
    end else if (state_q == S_WB) begin
      rf_we_o    = dec_we_i && (dec_rd_i != '0);
      rf_waddr_o = dec_rd_i;
      rf_wdata_o = res_q;
    end
  end

  assign bus.imem_req_o  = (state_q == S_FETCH);
  assign bus.imem_addr_o = pc_q;
  assign bus.dmem_req_o  = (state_q == S_MEM);
  assign instr_o         = instr_q;
  assign pc_o            = pc_q;
  assign retire_o        = (state_q == S_WB);
  assign halt_o          = (state_q == S_HALT);
  assign fault_o         = fault_q;

`ifdef CORE_SEQ_PERF_CNT_EN
  logic [63:0] cyc_q;
  logic [63:0] ret_q;
  logic        running;

  assign running = (state_q != S_RESET) && (state_q != S_CLEAR) && (state_q != S_HALT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (running)  cyc_q <= cyc_q + 64'd1;
      if (retire_o) ret_q <= ret_q + 64'd1;
    end
  end

  assign cycle_cnt_o   = cyc_q;
  assign instret_cnt_o = ret_q;
`else
  assign cycle_cnt_o   = '0;
  assign instret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized bench for core_seq_ctrl: a transaction-level model expands each instruction
// into its expected per-cycle outputs, which a single compare process checks every cycle.
module tb_core_seq_ctrl;
  localparam int          XLEN = 32;
  localparam int          NREG = 32;
  localparam int          TMO  = 4;
  localparam logic [31:0] RV   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_o;
  logic        dec_illegal_i = 1'b0, dec_mem_i = 1'b0, dec_we_i = 1'b0;
  logic [4:0]  dec_rd_i = '0;
  logic [31:0] exec_next_pc_i = '0, exec_result_i = '0;
  logic        rf_we_o, retire_o, halt_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, pc_o;
  logic [1:0]  fault_o;
  logic [63:0] cycle_cnt_o, instret_cnt_o;

  always #5 clk = ~clk;

  core_seq_ctrl_if #(.XLEN(XLEN)) bus ();

  core_seq_ctrl #(
    .XLEN(XLEN), .NUM_REGS(NREG), .RESET_VECTOR(RV), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .bus(bus), .instr_o(instr_o),
    .dec_illegal_i(dec_illegal_i), .dec_mem_i(dec_mem_i), .dec_we_i(dec_we_i),
    .dec_rd_i(dec_rd_i), .exec_next_pc_i(exec_next_pc_i), .exec_result_i(exec_result_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .pc_o(pc_o),
    .retire_o(retire_o), .halt_o(halt_o), .fault_o(fault_o),
    .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o)
  );

  typedef struct {
    bit          ireq, dreq, we, retire, halt, active;
    logic [4:0]  waddr;
    logic [31:0] wdata, pc, instr;
    logic [1:0]  fault;
    logic [63:0] cyc, ret;
  } exp_t;

  exp_t        exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] last_x5 = '0;

  // Architectural view of the core as the specification describes it.
  logic [31:0] m_pc = RV, m_instr = '0;
  bit          m_halt = 0;
  logic [1:0]  m_fault = '0;
  longint unsigned m_cyc = 0, m_ret = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t base();
    exp_t e;
    e = '{default: '0};
    e.pc    = m_pc;
    e.instr = m_instr;
    e.halt  = m_halt;
    e.fault = m_fault;
    return e;
  endfunction

  task automatic noise();
    bus.imem_ack_i   = 1'($urandom_range(0, 1));
    bus.dmem_ack_i   = 1'($urandom_range(0, 1));
    bus.imem_rdata_i = $urandom;
    dec_illegal_i    = 1'($urandom_range(0, 1));
    dec_mem_i        = 1'($urandom_range(0, 1));
    dec_we_i         = 1'($urandom_range(0, 1));
    dec_rd_i         = 5'($urandom_range(0, 31));
    exec_next_pc_i   = $urandom;
    exec_result_i    = $urandom;
  endtask

  // Queue the expectation for the current cycle, then advance to 1 time unit after the next edge.
  task automatic tick(input exp_t e);
`ifdef CORE_SEQ_PERF_CNT_EN
    e.cyc = m_cyc;
    e.ret = m_ret;
`else
    e.cyc = '0;
    e.ret = '0;
`endif
    exp_q.push_back(e);
    if (e.active) m_cyc++;
    if (e.retire) m_ret++;
    @(posedge clk);
    #1;
    noise();
  endtask

  // Current cycle is the RESET state with rst_i being released now.
  task automatic post_reset();
    exp_t e;
    m_pc = RV; m_instr = '0; m_halt = 0; m_fault = '0; m_cyc = 0; m_ret = 0;
    rst_i = 1'b0;
    tick(base());
    for (int i = 0; i < NREG; i++) begin
      e = base();
      e.we = 1'b1;
      e.waddr = 5'(i);
      e.wdata = '0;
      tick(e);
    end
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) tick(base());
  endtask

  task automatic reset_now();
    rst_i = 1'b1;
    tick(base());
    post_reset();
  endtask

  // li/ld = ack latency in cycles (0 = never acks); rst_at_mem = MEM cycle to assert reset in (0 = none).
  task automatic run_instr(input int li, input bit illegal, input bit mem, input int ld,
                           input bit we, input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] res, input logic [31:0] npc, input logic [31:0] ldata,
                           input int rst_at_mem, output int ncyc);
    exp_t e;
    logic [31:0] r;
    ncyc = 0;
    for (int k = 1; k <= ((li == 0) ? TMO : li); k++) begin
      e = base(); e.ireq = 1'b1; e.active = 1'b1;
      bus.imem_ack_i = (k == li);
      if (k == li) bus.imem_rdata_i = rdata;
      tick(e); ncyc++;
    end
    if (li == 0) begin m_halt = 1; m_fault = 2'd2; return; end
    m_instr = rdata;
    e = base(); e.active = 1'b1;
    dec_illegal_i = illegal;
    tick(e); ncyc++;
    if (illegal) begin m_halt = 1; m_fault = 2'd1; return; end
    e = base(); e.active = 1'b1;
    dec_mem_i = mem; exec_next_pc_i = npc; exec_result_i = res;
    tick(e); ncyc++;
    r = res;
    if (mem) begin
      for (int k = 1; k <= ((ld == 0) ? TMO : ld); k++) begin
        e = base(); e.dreq = 1'b1; e.active = 1'b1;
        bus.dmem_ack_i = (k == ld);
        if (k == ld) exec_result_i = ldata;
        if (k == rst_at_mem) rst_i = 1'b1;
        tick(e); ncyc++;
        if (k == rst_at_mem) begin post_reset(); return; end
      end
      if (ld == 0) begin m_halt = 1; m_fault = 2'd3; return; end
      r = ldata;
    end
    e = base(); e.active = 1'b1; e.retire = 1'b1;
    e.we = we && (rd != 5'd0); e.waddr = rd; e.wdata = r;
    dec_we_i = we; dec_rd_i = rd;
    tick(e); ncyc++;
    m_pc = npc;
  endtask

  always @(negedge clk) begin : compare
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rf_we_o && rf_waddr_o == 5'd5) last_x5 = rf_wdata_o;
      check("imem_req", bus.imem_req_o, e.ireq);
      check("imem_addr", bus.imem_addr_o, e.pc);
      check("dmem_req", bus.dmem_req_o, e.dreq);
      check("rf_we", rf_we_o, e.we);
      if (e.we) begin
        check("rf_waddr", rf_waddr_o, e.waddr);
        check("rf_wdata", rf_wdata_o, e.wdata);
      end
      check("retire", retire_o, e.retire);
      check("halt", halt_o, e.halt);
      check("fault", fault_o, e.fault);
      check("pc", pc_o, e.pc);
      check("instr", instr_o, e.instr);
      check("cycle_cnt", cycle_cnt_o, e.cyc);
      check("instret_cnt", instret_cnt_o, e.ret);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    noise();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    noise();
    post_reset();
    check("first_fetch_addr", bus.imem_addr_o, 32'h8000_0000);
    check("first_fetch_req", bus.imem_req_o, 1'b1);

    run_instr(1, 0, 0, 0, 1, 5'd5, 32'h0050_0293, 32'h1234, 32'h8000_0004, '0, 0, n);
    check("alu_cycles", n, 4);
    check("pc_after_alu", pc_o, 32'h8000_0004);
    check("x5_value", last_x5, 32'h1234);

    run_instr(1, 0, 1, 3, 1, 5'd0, 32'h0000_2003, 32'h10, 32'h8000_0008, 32'hdead_beef, 0, n);
    check("load_cycles", n, 7);

    run_instr(TMO, 0, 0, 0, 1, 5'd7, 32'h0070_0393, 32'h77, 32'h8000_000c, '0, 0, n);
    check("late_fetch_cycles", n, 7);

    for (int i = 0; i < 80; i++)
      run_instr($urandom_range(1, TMO), 0, 1'($urandom_range(0, 1)), $urandom_range(1, TMO),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                $urandom, $urandom, 0, n);

    run_instr(2, 1, 0, 0, 1, 5'd3, 32'hffff_ffff, '0, '0, '0, 0, n);
    check("illegal_halt", halt_o, 1'b1);
    check("illegal_fault", fault_o, 2'd1);
    halt_cycles(10);

    reset_now();
    run_instr(0, 0, 0, 0, 0, '0, '0, '0, '0, '0, 0, n);
    check("imem_to_fault", fault_o, 2'd2);
    check("imem_to_req_cycles", n, TMO);
    halt_cycles(6);

    reset_now();
    run_instr(1, 0, 1, 0, 1, 5'd9, 32'h1234_5678, 32'h5, 32'h8000_0004, '0, 0, n);
    check("dmem_to_fault", fault_o, 2'd3);
    halt_cycles(6);

    reset_now();
    for (int i = 0; i < 3; i++)
      run_instr($urandom_range(1, TMO), 0, 0, 0, 1, 5'($urandom_range(1, 31)), $urandom,
                $urandom, $urandom, $urandom, 0, n);
    run_instr(1, 0, 1, 4, 1, 5'd4, 32'h0000_3203, 32'h1, 32'h2, 32'h3, 2, n);
    check("pc_after_mid_reset", pc_o, RV);
    for (int i = 0; i < 3; i++)
      run_instr(1, 0, 0, 0, 1, 5'd6, $urandom, $urandom, $urandom, $urandom, 0, n);
`ifdef CORE_SEQ_PERF_CNT_EN
    check("instret_after_3", instret_cnt_o, 64'd3);
`else
    check("instret_tied_zero", instret_cnt_o, 64'd0);
`endif
    halt_cycles(0);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
